// File: rtl/mat2axi_sched_pkg.sv
// Shared types and constants for the row-major AXI burst scheduler.
package mat2axi_sched_pkg;

  localparam int ADDR_W_DEF    = 64;
  localparam int DATA_W_DEF    = 64;
  localparam int BPP_DEF       = 1;
  localparam int MAX_BURST_DEF = 16;
  localparam int MAX_OUTST_DEF = 8;

  // A stride of all ones means the row pitch equals the image width.
  localparam logic [31:0] STRIDE_USE_COLS = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    ISSUE = ST_ISSUE,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } sched_state_e;

  function automatic logic [7:0] burst_len(input logic [17:0] beats, input logic [17:0] max_beats);
    logic [17:0] n;
    if (beats > max_beats) begin
      n = max_beats;
    end else if (beats == 18'd0) begin
      n = 18'd1;
    end else begin
      n = beats;
    end
    return 8'(n - 18'd1);
  endfunction

endpackage

// File: rtl/mat2axi_outst_ctr.sv
// Count of bursts issued but not yet acknowledged; a response with nothing
// in flight is dropped rather than wrapping the counter.
module mat2axi_outst_ctr
  import mat2axi_sched_pkg::*;
#(
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic full_nxt,
  output logic empty
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          dec_ok_s;

  assign dec_ok_s = dec && (cnt_r != CNT_ZERO);

  // next count: an accept and a response in the same cycle cancel out
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (inc && !dec_ok_s) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else if (dec_ok_s && !inc) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // in-flight count register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign full     = (cnt_r == CNT_MAX);
  assign full_nxt = (cnt_nxt_s == CNT_MAX);
  assign empty    = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/mat2axi_row_sched.sv
// Walks an image frame row by row and emits burst commands (address, beats-1),
// throttled by the number of bursts still awaiting a B response.
module mat2axi_row_sched
  import mat2axi_sched_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BPP       = BPP_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int MAX_OUTST = MAX_OUTST_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       rows,
  input  logic [15:0]       cols,
  input  logic [31:0]       stride,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              rsp_valid
);

  localparam int BPB    = DATA_W / 8;
  localparam int BPB_SH = $clog2(BPB);

  sched_state_e      state_r, state_nxt_s;
  logic [ADDR_W-1:0] base_r, base_nxt_s, row_addr_r, row_addr_nxt_s, cmd_addr_r, cmd_addr_nxt_s;
  logic [15:0]       rows_r, rows_nxt_s, cols_r, cols_nxt_s, row_r, row_nxt_s;
  logic [31:0]       stride_r, stride_nxt_s;
  logic [17:0]       pitch_r, pitch_nxt_s, row_beats_r, row_beats_nxt_s, beats_left_r, beats_left_nxt_s;
  logic [7:0]        cmd_len_r, cmd_len_nxt_s;
  logic              cmd_valid_r, cmd_valid_nxt_s, ap_done_r, ap_done_nxt_s, ap_ready_r, ap_ready_nxt_s;

  logic [15:0]       cols_eff_s;
  logic [17:0]       pitch_s, row_beats_s, burst_beats_s, remain_s;
  logic [18:0]       row_bytes_s;
  logic [ADDR_W-1:0] burst_bytes_s, next_row_addr_s;
  logic              accept_s, full_s, full_nxt_s, empty_s, last_row_s;

  assign cols_eff_s      = (stride_r == STRIDE_USE_COLS) ? cols_r : stride_r[15:0];
  assign pitch_s         = 18'(cols_eff_s) * 18'(BPP);
  assign row_bytes_s     = 19'(cols_r) * 19'(BPP) + 19'(BPB - 1);
  assign row_beats_s     = 18'(row_bytes_s >> BPB_SH);
  assign burst_beats_s   = {10'd0, cmd_len_r} + 18'd1;
  assign remain_s        = beats_left_r - burst_beats_s;
  assign burst_bytes_s   = ADDR_W'(burst_beats_s) << BPB_SH;
  assign next_row_addr_s = row_addr_r + ADDR_W'(pitch_r);
  assign last_row_s      = (row_r == rows_r - 16'd1);
  assign accept_s        = cmd_valid_r && cmd_ready && !full_s;

  mat2axi_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_outst_ctr (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .inc      (accept_s),
    .dec      (rsp_valid),
    .full     (full_s),
    .full_nxt (full_nxt_s),
    .empty    (empty_s)
  );

  // frame sequencing and burst address walk
  always_comb begin
    state_nxt_s      = state_r;
    base_nxt_s       = base_r;
    rows_nxt_s       = rows_r;
    cols_nxt_s       = cols_r;
    stride_nxt_s     = stride_r;
    pitch_nxt_s      = pitch_r;
    row_beats_nxt_s  = row_beats_r;
    row_nxt_s        = row_r;
    row_addr_nxt_s   = row_addr_r;
    beats_left_nxt_s = beats_left_r;
    cmd_addr_nxt_s   = cmd_addr_r;
    cmd_len_nxt_s    = cmd_len_r;
    ap_done_nxt_s    = ap_done_r;
    ap_ready_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          base_nxt_s     = base_addr;
          rows_nxt_s     = rows;
          cols_nxt_s     = cols;
          stride_nxt_s   = stride;
          ap_ready_nxt_s = 1'b1;
          state_nxt_s    = SETUP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETUP: begin
        pitch_nxt_s     = pitch_s;
        row_beats_nxt_s = row_beats_s;
        if ((rows_r == 16'd0) || (cols_r == 16'd0)) begin
          ap_done_nxt_s = 1'b1;
          state_nxt_s   = DONE;
        end else begin
          row_nxt_s        = 16'd0;
          row_addr_nxt_s   = base_r;
          cmd_addr_nxt_s   = base_r;
          beats_left_nxt_s = row_beats_s;
          cmd_len_nxt_s    = burst_len(row_beats_s, 18'(MAX_BURST));
          state_nxt_s      = ISSUE;
        end
      end
      ISSUE: begin
        if (!accept_s) begin
          state_nxt_s = ISSUE;
        end else if (remain_s != 18'd0) begin
          cmd_addr_nxt_s   = cmd_addr_r + burst_bytes_s;
          beats_left_nxt_s = remain_s;
          cmd_len_nxt_s    = burst_len(remain_s, 18'(MAX_BURST));
        end else if (last_row_s) begin
          beats_left_nxt_s = 18'd0;
          state_nxt_s      = DRAIN;
        end else begin
          // row finished: jump straight to the next row with no idle cycle
          row_nxt_s        = row_r + 16'd1;
          row_addr_nxt_s   = next_row_addr_s;
          cmd_addr_nxt_s   = next_row_addr_s;
          beats_left_nxt_s = row_beats_r;
          cmd_len_nxt_s    = burst_len(row_beats_r, 18'(MAX_BURST));
        end
      end
      DRAIN: begin
        if (empty_s) begin
          ap_done_nxt_s = 1'b1;
          state_nxt_s   = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE: begin
        if (ap_continue) begin
          ap_done_nxt_s = 1'b0;
          state_nxt_s   = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        ap_done_nxt_s = 1'b0;
        state_nxt_s   = IDLE;
      end
    endcase
    cmd_valid_nxt_s = (state_nxt_s == ISSUE) && !full_nxt_s;
  end

  // state and output registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_r      <= IDLE;
      base_r       <= {ADDR_W{1'b0}};
      rows_r       <= 16'd0;
      cols_r       <= 16'd0;
      stride_r     <= 32'd0;
      pitch_r      <= 18'd0;
      row_beats_r  <= 18'd0;
      row_r        <= 16'd0;
      row_addr_r   <= {ADDR_W{1'b0}};
      beats_left_r <= 18'd0;
      cmd_addr_r   <= {ADDR_W{1'b0}};
      cmd_len_r    <= 8'd0;
      cmd_valid_r  <= 1'b0;
      ap_done_r    <= 1'b0;
      ap_ready_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      base_r       <= base_nxt_s;
      rows_r       <= rows_nxt_s;
      cols_r       <= cols_nxt_s;
      stride_r     <= stride_nxt_s;
      pitch_r      <= pitch_nxt_s;
      row_beats_r  <= row_beats_nxt_s;
      row_r        <= row_nxt_s;
      row_addr_r   <= row_addr_nxt_s;
      beats_left_r <= beats_left_nxt_s;
      cmd_addr_r   <= cmd_addr_nxt_s;
      cmd_len_r    <= cmd_len_nxt_s;
      cmd_valid_r  <= cmd_valid_nxt_s;
      ap_done_r    <= ap_done_nxt_s;
      ap_ready_r   <= ap_ready_nxt_s;
    end
  end

  assign ap_done   = ap_done_r;
  assign ap_ready  = ap_ready_r;
  assign ap_idle   = (state_r == IDLE) && !ap_start;
  assign cmd_valid = cmd_valid_r;
  assign cmd_addr  = cmd_addr_r;
  assign cmd_len   = cmd_len_r;

endmodule

// File: tb/tb_mat2axi_row_sched.sv
// Randomized bench for mat2axi_row_sched: every frame's command list is
// predicted from the frame geometry and compared against accepted commands.
module tb_mat2axi_row_sched;

  localparam logic [31:0] SENT      = 32'hFFFF_FFFF;
  localparam int          MAX_OUTST = 8;
  localparam int          MAX_BURST = 16;
  localparam int          BYTES_BEAT = 8;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n, ap_start, ap_continue, ap_done, ap_idle, ap_ready;
  logic [63:0] base_addr;
  logic [15:0] rows, cols;
  logic [31:0] stride;
  logic        cmd_valid, cmd_ready, rsp_valid;
  logic [63:0] cmd_addr;
  logic [7:0]  cmd_len;

  always #5 ap_clk = ~ap_clk;

  mat2axi_row_sched dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready), .base_addr(base_addr),
    .rows(rows), .cols(cols), .stride(stride), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .rsp_valid(rsp_valid)
  );

  int tests_run = 0, tests_failed = 0;
  logic [71:0] exp_q[$];
  logic [71:0] got_q[$];
  int  ready_pct = 100, rsp_pct = 50, hold_left = 0;
  int  outst = 0, accepted = 0;
  int  viol_stable = 0, viol_full = 0, viol_spurious = 0;
  bit  frame_active = 1'b0, prev_stall = 1'b0;
  logic [63:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected commands: each row starts at base + row*pitch, split into bursts of <= 16 beats.
  task automatic build_model(input logic [63:0] b, input logic [15:0] nr, input logic [15:0] nc,
                             input logic [31:0] st);
    longint unsigned pitch, beats, left, n, a;
    exp_q.delete();
    pitch = (st == SENT) ? longint'(nc) : longint'(st[15:0]);
    beats = (longint'(nc) + BYTES_BEAT - 1) / BYTES_BEAT;
    for (int r = 0; r < int'(nr); r++) begin
      a    = b + longint'(r) * pitch;
      left = beats;
      while (left > 0) begin
        n = (left > MAX_BURST) ? MAX_BURST : left;
        exp_q.push_back({64'(a), 8'(n - 1)});
        a    = a + n * BYTES_BEAT;
        left = left - n;
      end
    end
  endtask

  task automatic step();
    logic acc, dec;
    logic [71:0] e;
    @(negedge ap_clk);
    if (prev_stall && (!cmd_valid || cmd_addr !== prev_addr || cmd_len !== prev_len)) viol_stable++;
    if (cmd_valid && outst >= MAX_OUTST) viol_full++;
    if (cmd_valid && exp_q.size() == 0) viol_spurious++;
    cmd_ready = (int'($urandom_range(99)) < ready_pct);
    if (hold_left > 0) begin
      rsp_valid = 1'b0;
      hold_left--;
    end else begin
      rsp_valid = (int'($urandom_range(99)) < ((outst > 0) ? rsp_pct : 5));
    end
    if (frame_active && !ap_done) begin
      ap_start    = ($urandom_range(7) == 0);
      ap_continue = ($urandom_range(7) == 0);
      base_addr   = {$urandom, $urandom};
      rows        = 16'($urandom);
      cols        = 16'($urandom);
      stride      = $urandom;
    end else begin
      ap_start    = 1'b0;
      ap_continue = 1'b0;
    end
    acc = cmd_valid && cmd_ready;
    if (acc) begin
      got_q.push_back({cmd_addr, cmd_len});
      accepted++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cmd_addr", cmd_addr, e[71:8]);
        chk("cmd_len", 64'(cmd_len), 64'(e[7:0]));
      end
    end
    dec   = rsp_valid && (outst > 0);
    outst = outst + int'(acc) - int'(dec);
    prev_stall = cmd_valid && !cmd_ready;
    prev_addr  = cmd_addr;
    prev_len   = cmd_len;
  endtask

  task automatic start_frame(input logic [63:0] b, input logic [15:0] nr, input logic [15:0] nc,
                             input logic [31:0] st);
    build_model(b, nr, nc, st);
    got_q.delete();
    accepted = 0; viol_stable = 0; viol_full = 0; viol_spurious = 0; prev_stall = 1'b0;
    @(negedge ap_clk);
    chk("idle_pre", 64'(ap_idle), 64'd1);
    base_addr = b; rows = nr; cols = nc; stride = st;
    ap_start = 1'b1; cmd_ready = 1'b0; rsp_valid = 1'b0;
    @(negedge ap_clk);
    chk("ready_pulse", 64'(ap_ready), 64'd1);
    chk("idle_busy", 64'(ap_idle), 64'd0);
    ap_start = 1'b0;
    frame_active = 1'b1;
    step();
    chk("ready_once", 64'(ap_ready), 64'd0);
    if (nr == 16'd0 || nc == 16'd0) chk("zero_done", 64'(ap_done), 64'd1);
  endtask

  task automatic finish_frame(input bit hold_chk);
    int n = 0;
    bit pending = hold_chk;
    while (!ap_done && n < 3000) begin
      step();
      n++;
      if (pending && hold_left == 0) begin
        pending = 1'b0;
        chk("withheld_accepts", 64'(accepted), 64'(MAX_OUTST));
        chk("withheld_valid", 64'(cmd_valid), 64'd0);
      end
    end
    chk("done_reached", 64'(ap_done), 64'd1);
    chk("cmds_left", 64'(exp_q.size()), 64'd0);
    chk("outst_at_done", 64'(outst), 64'd0);
    chk("cmd_stable", 64'(viol_stable), 64'd0);
    chk("outst_gate", 64'(viol_full), 64'd0);
    chk("spurious_valid", 64'(viol_spurious), 64'd0);
    frame_active = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; ap_start = 1'b0; ap_continue = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("done_sticky", 64'(ap_done), 64'd1);
    chk("idle_in_done", 64'(ap_idle), 64'd0);
    ap_continue = 1'b1;
    @(negedge ap_clk);
    ap_continue = 1'b0;
    chk("done_clear", 64'(ap_done), 64'd0);
    chk("idle_post", 64'(ap_idle), 64'd1);
  endtask

  task automatic run_frame(input logic [63:0] b, input logic [15:0] nr, input logic [15:0] nc,
                           input logic [31:0] st, input int hold);
    hold_left = hold;
    start_frame(b, nr, nc, st);
    finish_frame(hold > 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_addr"}, cmd_addr, 64'd0);
    chk({tag, "_len"}, 64'(cmd_len), 64'd0);
    chk({tag, "_done"}, 64'(ap_done), 64'd0);
    chk({tag, "_ready"}, 64'(ap_ready), 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rb;
    logic [31:0] rs;
    int n;
    ap_rst_n = 1'b1; ap_start = 1'b0; ap_continue = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0;
    base_addr = 64'd0; rows = 16'd0; cols = 16'd0; stride = 32'd0;
    #3 ap_rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    chk("rst_idle", 64'(ap_idle), 64'd1);
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // responses with nothing in flight must be ignored
    @(negedge ap_clk) rsp_valid = 1'b1;
    repeat (2) @(negedge ap_clk);
    rsp_valid = 1'b0;

    ready_pct = 100; rsp_pct = 50;
    run_frame(64'h1000, 16'd2, 16'd64, SENT, 0);
    chk("two_row_count", 64'(got_q.size()), 64'd2);
    chk("two_row_a0", got_q[0][71:8], 64'h1000);
    chk("two_row_l0", 64'(got_q[0][7:0]), 64'd7);
    chk("two_row_a1", got_q[1][71:8], 64'h1040);
    chk("two_row_l1", 64'(got_q[1][7:0]), 64'd7);

    run_frame(64'h1000, 16'd2, 16'd64, 32'd128, 0);
    chk("stride_a1", got_q[1][71:8], 64'h1080);

    ready_pct = 60;
    run_frame(64'h1000, 16'd1, 16'd300, SENT, 0);
    chk("split_count", 64'(got_q.size()), 64'd3);
    chk("split_a0", got_q[0][71:8], 64'h1000);
    chk("split_a1", got_q[1][71:8], 64'h1080);
    chk("split_a2", got_q[2][71:8], 64'h1100);
    chk("split_l1", 64'(got_q[1][7:0]), 64'd15);
    chk("split_l2", 64'(got_q[2][7:0]), 64'd5);

    ready_pct = 100;
    run_frame(64'h2000, 16'd10, 16'd8, SENT, 40);
    run_frame(64'h3000, 16'd0, 16'd64, SENT, 0);
    run_frame(64'h3000, 16'd4, 16'd0, SENT, 0);
    run_frame(64'hFFFF_FFFF_FFFF_FFC0, 16'd3, 16'd100, SENT, 0);

    for (int f = 0; f < 12; f++) begin
      rb = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FF00 + 64'($urandom_range(255)))
                                    : {$urandom, $urandom};
      rs = ($urandom_range(1) == 0) ? SENT : 32'($urandom_range(600));
      ready_pct = int'($urandom_range(30, 100));
      rsp_pct   = int'($urandom_range(20, 80));
      run_frame(rb, 16'($urandom_range(5)), 16'($urandom_range(400)), rs, 0);
    end

    // stall mid-frame, then abandon the frame with a reset
    ready_pct = 100; rsp_pct = 30;
    start_frame(64'h1000, 16'd4, 16'd300, SENT);
    n = 0;
    while (accepted < 3 && n < 200) begin
      step();
      n++;
    end
    chk("abort_progress", 64'(accepted >= 3), 64'd1);
    ready_pct = 0; viol_stable = 0;
    repeat (6) step();
    chk("stall_valid", 64'(cmd_valid), 64'd1);
    chk("stall_stable", 64'(viol_stable), 64'd0);
    frame_active = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b0; ap_start = 1'b0; ap_continue = 1'b0; rsp_valid = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1 chk("abort_idle", 64'(ap_idle), 64'd1);
    exp_q.delete(); outst = 0; accepted = 0; viol_spurious = 0; prev_stall = 1'b0;
    ready_pct = 100; rsp_pct = 50;
    repeat (10) step();
    chk("abort_no_accept", 64'(accepted), 64'd0);
    chk("abort_no_valid", 64'(viol_spurious), 64'd0);

    run_frame(64'h8000, 16'd3, 16'd200, 32'd256, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
